pe_row_array: RTL and testbench



---
 rtl/accumulator_pkg.sv | 28 ++
 rtl/pe_row_array_if.sv | 29 ++
 rtl/pe_row_array_pe_row.sv | 55 +++++
 rtl/pe_row_array.sv | 86 ++++++++
 tb/tb_pe_row_array.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_pkg
// Purpose  : Width formulas and default sizes shared by the PE row array
//            (producer) and the accumulator (consumer) so both ends agree.
// Revision : 1.0 - initial release
// ============================================================================
package accumulator_pkg;

   localparam int IFM_BIT_DEF = 8;
   localparam int W_BIT_DEF   = 8;
   localparam int K_DEF       = 3;
   localparam int IN_CH_DEF   = 512;

   // Per-row partial sum: one product plus growth from K lanes over IN_CH beats.
   function automatic int bit_pe(input int ifm_bit, input int w_bit,
                                 input int k, input int in_ch);
      return ifm_bit + w_bit + $clog2(k * in_ch);
   endfunction

   // Accumulator side additionally sums the K row partial sums.
   function automatic int bit_accumulator(input int ifm_bit, input int w_bit,
                                          input int k, input int in_ch);
      return bit_pe(ifm_bit, w_bit, k, in_ch) + $clog2(k);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_row_array_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_array_if
// Purpose  : Beat input (window + kernel) and packed PE output bundle.
//            master = beat source / PE sink, slave = the PE row array.
// Revision : 1.0 - initial release
// ============================================================================
interface pe_row_array_if
   import accumulator_pkg::*;
#(
   parameter int IFM_BIT = IFM_BIT_DEF,
   parameter int W_BIT   = W_BIT_DEF,
   parameter int K       = K_DEF,
   parameter int IN_CH   = IN_CH_DEF
);

   localparam int BIT_PE = bit_pe(IFM_BIT, W_BIT, K, IN_CH);

   logic                     in_valid;
   logic [K*K*IFM_BIT-1:0]   ifm;
   logic [K*K*W_BIT-1:0]     weight;
   logic                     out_valid;
   logic [K*BIT_PE-1:0]      PE;

   modport master (output in_valid, ifm, weight, input  out_valid, PE);
   modport slave  (input  in_valid, ifm, weight, output out_valid, PE);

endinterface
`default_nettype wire

// File: rtl/pe_row_array_pe_row.sv
`default_nettype none
// ============================================================================
// Module   : pe_row
// Purpose  : One kernel row: K-lane multiply, lane reduction, and a
//            load/accumulate register holding the running row partial sum.
// Revision : 1.0 - initial release
// ============================================================================
module pe_row #(
   parameter int IFM_BIT = 8,
   parameter int W_BIT   = 8,
   parameter int K       = 3,
   parameter int BIT_PE  = 27
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   beat,
   input  logic                   load,
   input  logic [K*IFM_BIT-1:0]   ifm_row,
   input  logic [K*W_BIT-1:0]     w_row,
   output logic [BIT_PE-1:0]      sum_next
);

   localparam int PROD_W = IFM_BIT + W_BIT;

   logic [PROD_W-1:0] prod [K];
   logic [BIT_PE-1:0] rowsum;
   logic [BIT_PE-1:0] acc;

   for (genvar i = 0; i < K; i++) begin : g_lane
      assign prod[i] = PROD_W'(ifm_row[i*IFM_BIT +: IFM_BIT])
                     * PROD_W'(w_row[i*W_BIT +: W_BIT]);
   end

   // Sum the K zero-extended lane products into one row sum.
   always_comb begin
      rowsum = '0;
      for (int i = 0; i < K; i++) begin
         rowsum = rowsum + BIT_PE'(prod[i]);
      end
   end

   // First beat of a group loads, discarding the previous group with no dead cycle.
   assign sum_next = load ? rowsum : (acc + rowsum);

   // Running partial sum only advances on qualified beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (beat) begin
         acc <= sum_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pe_row_array.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_array
// Purpose  : K kernel rows accumulating dot products over IN_CH beats; emits
//            the packed row partial sums with a one-cycle out_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_array
   import accumulator_pkg::*;
#(
   parameter int IFM_BIT = IFM_BIT_DEF,
   parameter int W_BIT   = W_BIT_DEF,
   parameter int K       = K_DEF,
   parameter int IN_CH   = IN_CH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   pe_row_array_if.slave bus
);

   localparam int BIT_PE = bit_pe(IFM_BIT, W_BIT, K, IN_CH);
   // A single-channel group still needs a 1-bit counter to stay legal.
   localparam int CNT_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_CH - 1);

   logic [CNT_W-1:0]    count;
   logic                first_beat;
   logic                last_beat;
   logic [BIT_PE-1:0]   row_next [K];
   logic [K*BIT_PE-1:0] pe_q;
   logic                valid_q;

   assign first_beat = (count == '0);
   assign last_beat  = bus.in_valid && (count == LAST_CNT);

   // Beat counter: advances on valid beats only, wraps after the last channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (bus.in_valid) begin
         count <= (count == LAST_CNT) ? '0 : (count + 1'b1);
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_row
      pe_row #(
         .IFM_BIT (IFM_BIT),
         .W_BIT   (W_BIT),
         .K       (K),
         .BIT_PE  (BIT_PE)
      ) u_row (
         .clk      (clk),
         .rst_n    (rst_n),
         .beat     (bus.in_valid),
         .load     (first_beat),
         .ifm_row  (bus.ifm[r*K*IFM_BIT +: K*IFM_BIT]),
         .w_row    (bus.weight[r*K*W_BIT +: K*W_BIT]),
         .sum_next (row_next[r])
      );
   end

   // Capture completed row sums; held until the next group completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_q <= '0;
      end else if (last_beat) begin
         for (int r = 0; r < K; r++) begin
            pe_q[r*BIT_PE +: BIT_PE] <= row_next[r];
         end
      end
   end

   // One-cycle completion pulse the cycle after the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= last_beat;
      end
   end

   assign bus.PE        = pe_q;
   assign bus.out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_row_array
// Purpose  : Self-checking bench for pe_row_array (K=3, IN_CH=4 plus a
//            default IN_CH=512 instance for the full-range case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_row_array;

   localparam int NB  = 4;
   localparam int BP  = 20;   // 8+8+clog2(12)
   localparam int BP2 = 27;   // 8+8+clog2(1536)

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int bcnt   = 0;

   typedef struct {
      logic [3*BP-1:0] pe;
      int              cyc;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      int f0; int f1; int f2; int w; int gap; int e0; int e1; int e2;
   } vec_t;
   vec_t tbl [5];

   int              pulses2 = 0;
   logic [3*BP2-1:0] pe2;
   int              cyc2 = 0;

   pe_row_array_if #(.IFM_BIT(8), .W_BIT(8), .K(3), .IN_CH(4))   bus ();
   pe_row_array_if #(.IFM_BIT(8), .W_BIT(8), .K(3), .IN_CH(512)) bus2 ();

   pe_row_array #(.IFM_BIT(8), .W_BIT(8), .K(3), .IN_CH(4)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus.slave)
   );
   pe_row_array #(.IFM_BIT(8), .W_BIT(8), .K(3), .IN_CH(512)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (bus2.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every pulse must match the oldest expected group result.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pulse: unexpected out_valid at cycle %0d, PE=%h", cyc, bus.PE);
         end else begin
            e = sb.pop_front();
            if (bus.PE !== e.pe || cyc != e.cyc) begin
               errors++;
               $display("FAIL group: got PE=%h at cycle %0d, expected PE=%h at cycle %0d",
                        bus.PE, cyc, e.pe, e.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus2.out_valid === 1'b1) begin
         pulses2++;
         pe2  = bus2.PE;
         cyc2 = cyc;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] uni(input int a, input int b, input int c);
      logic [71:0] v;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            v[(r*3+k)*8 +: 8] = 8'((r == 0) ? a : (r == 1) ? b : c);
      return v;
   endfunction

   function automatic logic [71:0] splat(input int x);
      return uni(x, x, x);
   endfunction

   function automatic logic [3*BP-1:0] pack3(input int a, input int b, input int c);
      return {BP'(c), BP'(b), BP'(a)};
   endfunction

   // One valid beat; on the group's last beat queue its expected result.
   task automatic beat(input logic [71:0] f, input logic [71:0] w,
                       input logic [3*BP-1:0] exp,
                       input bit hold_chk, input logic [3*BP-1:0] hold);
      sb_t e;
      bus.in_valid = 1'b1;
      bus.ifm      = f;
      bus.weight   = w;
      if (bcnt == NB-1) begin
         e.pe  = exp;
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
      bcnt = (bcnt + 1) % NB;
      if (hold_chk) begin
         @(negedge clk);
         chk("pe_hold", 128'(bus.PE), 128'(hold));
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b0;
         bus.ifm      = 72'({$urandom(), $urandom(), $urandom()});
         bus.weight   = 72'({$urandom(), $urandom(), $urandom()});
         @(posedge clk); #1;
      end
   endtask

   task automatic group(input logic [71:0] f, input logic [71:0] w,
                        input logic [3*BP-1:0] exp, input int gap);
      for (int b = 0; b < NB; b++) begin
         beat(f, w, exp, 1'b0, '0);
         if (gap != 0 && b < NB-1) idle((b == 2) ? 1 : 2);
      end
   endtask

   initial begin
      logic [71:0] fa [NB];
      logic [71:0] wa [NB];
      int          m [3];
      int          last_drv;

      bus.in_valid  = 1'b0;
      bus.ifm       = '0;
      bus.weight    = '0;
      bus2.in_valid = 1'b0;
      bus2.ifm      = '0;
      bus2.weight   = '0;

      tbl[0] = '{1, 2, 3, 1, 0, 12, 24, 36};
      tbl[1] = '{1, 2, 3, 1, 1, 12, 24, 36};
      tbl[2] = '{5, 0, 7, 2, 0, 120, 0, 168};
      tbl[3] = '{255, 255, 255, 255, 1, 780300, 780300, 780300};
      tbl[4] = '{0, 9, 4, 6, 1, 0, 648, 288};

      // Asynchronous reset between clock edges clears outputs immediately.
      #13 rst_n = 1'b0;
      #1;
      chk("rst_valid",  128'(bus.out_valid), 128'(0));
      chk("rst_pe",     128'(bus.PE),        128'(0));
      chk("rst_valid2", 128'(bus2.out_valid), 128'(0));
      chk("rst_pe2",    128'(bus2.PE),        128'(0));
      #18 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
         chk("idle_valid", 128'(bus.out_valid), 128'(0));
         chk("idle_pe",    128'(bus.PE),        128'(0));
         @(posedge clk); #1;
      end

      // Table-driven groups: contiguous and gapped beats.
      for (int t = 0; t < 5; t++) begin
         group(uni(tbl[t].f0, tbl[t].f1, tbl[t].f2), splat(tbl[t].w),
               pack3(tbl[t].e0, tbl[t].e1, tbl[t].e2), tbl[t].gap);
         idle(2);
      end

      // Random per-lane groups against a reference model.
      for (int g = 0; g < 2; g++) begin
         m = '{0, 0, 0};
         for (int b = 0; b < NB; b++) begin
            fa[b] = 72'({$urandom(), $urandom(), $urandom()});
            wa[b] = 72'({$urandom(), $urandom(), $urandom()});
            for (int r = 0; r < 3; r++)
               for (int k = 0; k < 3; k++)
                  m[r] += int'(fa[b][(r*3+k)*8 +: 8]) * int'(wa[b][(r*3+k)*8 +: 8]);
         end
         for (int b = 0; b < NB; b++) begin
            beat(fa[b], wa[b], pack3(m[0], m[1], m[2]), 1'b0, '0);
            if (g == 1 && b < NB-1) idle(1);
         end
         idle(1);
      end

      // Back-to-back groups; PE must hold group A's result until B completes.
      group(splat(1), splat(1), pack3(12, 12, 12), 0);
      for (int b = 0; b < NB; b++)
         beat(splat(2), splat(3), pack3(72, 72, 72), 1'b1, pack3(12, 12, 12));
      idle(3);

      // Reset mid-group: aborted beats must not produce or pollute a result.
      beat(splat(7), splat(7), '0, 1'b0, '0);
      beat(splat(7), splat(7), '0, 1'b0, '0);
      bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_pe",    128'(bus.PE),        128'(0));
      chk("midrst_valid", 128'(bus.out_valid), 128'(0));
      #1 rst_n = 1'b1;
      bcnt = 0;
      @(posedge clk); #1;
      group(splat(1), splat(1), pack3(12, 12, 12), 0);
      idle(3);

      // Full-size group on the IN_CH=512 instance, all operands at maximum.
      last_drv = 0;
      for (int b = 0; b < 512; b++) begin
         bus2.in_valid = 1'b1;
         bus2.ifm      = splat(255);
         bus2.weight   = splat(255);
         last_drv      = cyc;
         @(posedge clk); #1;
      end
      bus2.in_valid = 1'b0;
      for (int i = 0; i < 6 && pulses2 == 0; i++) begin
         @(posedge clk); #1;
      end
      chk("max_pulses", 128'(pulses2), 128'(1));
      chk("max_pe",     128'(pe2),     128'({3{27'd99878400}}));
      chk("max_cycle",  128'(cyc2),    128'(last_drv + 1));

      idle(4);
      chk("sb_drained", 128'(sb.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
